ram_dump_ctrl: RTL and testbench

RAM_DUMP_CTRL -- requirements
Module: ram_dump_ctrl

---
 rtl/ram_dump_ctrl_if.sv | 30 +++
 rtl/ram_dump_ctrl.sv | 108 ++++++++++
 tb/tb_ram_dump_ctrl.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_dump_ctrl_if.sv
// rtl/ram_dump_ctrl_if.sv - memory bus and dump stream signals for ram_dump_ctrl
interface ram_dump_ctrl_if;
  logic        override_ctrl;
  logic        dren;
  logic        dwen;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        iren;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dump_valid;
  logic        dump_ready;
  logic [31:0] dump_addr;
  logic [31:0] dump_data;

  modport master (
    output override_ctrl, dren, dwen, daddr, dstore, iren, iaddr,
    output dump_valid, dump_addr, dump_data,
    input  dwait, dload, iwait, iload, dump_ready
  );

  modport slave (
    input  override_ctrl, dren, dwen, daddr, dstore, iren, iaddr,
    input  dump_valid, dump_addr, dump_data,
    output dwait, dload, iwait, iload, dump_ready
  );
endinterface

// File: rtl/ram_dump_ctrl.sv
// rtl/ram_dump_ctrl.sv - reads DUMP_WORDS words from BASE_ADDR and streams (addr, data) pairs out
// Optional RAM_DUMP_SKIP_ZERO_EN: words read as zero are dropped instead of streamed.
module ram_dump_ctrl #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned DUMP_WORDS = 1024
) (
  input  logic CLK,
  input  logic nRST,
  input  logic start,
  output logic busy,
  output logic done,
  ram_dump_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, READ, OUT, DONE} state_t;

  localparam logic [31:0] LAST_IDX = 32'(DUMP_WORDS) - 32'd1;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] data_q, data_d;
  logic        advance;

  logic unused_imem;
  assign unused_imem = ^{bus.iwait, bus.iload};

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= IDLE;
      addr_q  <= BASE_ADDR;
      cnt_q   <= 32'd0;
      data_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    advance = 1'b0;

    bus.override_ctrl = 1'b0;
    bus.dren          = 1'b0;
    bus.dwen          = 1'b0;
    bus.daddr         = 32'd0;
    bus.dstore        = 32'd0;
    bus.iren          = 1'b0;
    bus.iaddr         = 32'd0;
    bus.dump_valid    = 1'b0;
    bus.dump_addr     = 32'd0;
    bus.dump_data     = 32'd0;
    busy              = 1'b0;
    done              = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = BASE_ADDR;
          cnt_d   = 32'd0;
          state_d = (DUMP_WORDS == 0) ? DONE : READ;
        end
      end
      READ: begin
        bus.override_ctrl = 1'b1;
        busy              = 1'b1;
        bus.dren          = 1'b1;
        bus.daddr         = addr_q;
        if (!bus.dwait) begin
          data_d  = bus.dload;
          state_d = OUT;
`ifdef RAM_DUMP_SKIP_ZERO_EN
          if (bus.dload == 32'd0) advance = 1'b1;
`endif
        end
      end
      OUT: begin
        bus.override_ctrl = 1'b1;
        busy              = 1'b1;
        bus.dump_valid    = 1'b1;
        bus.dump_addr     = addr_q;
        bus.dump_data     = data_q;
        if (bus.dump_ready) advance = 1'b1;
      end
      DONE: begin
        bus.override_ctrl = 1'b1;
        busy              = 1'b1;
        done              = 1'b1;
        state_d           = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Shared by an accepted OUT word and, when enabled, a skipped zero word in READ.
    if (advance) begin
      addr_d  = addr_q + 32'd4;
      cnt_d   = cnt_q + 32'd1;
      state_d = (cnt_q == LAST_IDX) ? DONE : READ;
    end
  end

endmodule

// File: tb/tb_ram_dump_ctrl.sv
// tb/tb_ram_dump_ctrl.sv - self-checking bench for ram_dump_ctrl
module tb_ram_dump_ctrl;
  localparam int NI = 4;
  localparam logic [31:0] BASES [NI] = '{32'h0000_0100, 32'hFFFF_FFFC, 32'h0000_0200, 32'h0000_0300};
  localparam int unsigned WORDS [NI] = '{4, 2, 3, 0};
`ifdef RAM_DUMP_SKIP_ZERO_EN
  localparam int SKIP = 1;
`else
  localparam int SKIP = 0;
`endif

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  logic [NI-1:0] start_v, busy_v, done_v, ovr_v, dren_v, dwen_v, iren_v;
  logic [NI-1:0] dwait_v, dump_valid_v, dump_ready_v;
  logic [31:0]   daddr_v [NI];
  logic [31:0]   dstore_v [NI];
  logic [31:0]   iaddr_v [NI];
  logic [31:0]   dload_v [NI];
  logic [31:0]   dump_addr_v [NI];
  logic [31:0]   dump_data_v [NI];

  int wait_cfg [NI];
  int stall_cfg [NI];
  int wcnt [NI];
  int scnt [NI];

  for (genvar g = 0; g < NI; g++) begin : gen
    ram_dump_ctrl_if bus ();
    ram_dump_ctrl #(.BASE_ADDR(BASES[g]), .DUMP_WORDS(WORDS[g])) dut (
      .CLK(CLK), .nRST(nRST), .start(start_v[g]), .busy(busy_v[g]), .done(done_v[g]), .bus(bus)
    );
    assign bus.dwait       = dwait_v[g];
    assign bus.dload       = dload_v[g];
    assign bus.iwait       = 1'b0;
    assign bus.iload       = 32'd0;
    assign bus.dump_ready  = dump_ready_v[g];
    assign ovr_v[g]        = bus.override_ctrl;
    assign dren_v[g]       = bus.dren;
    assign dwen_v[g]       = bus.dwen;
    assign iren_v[g]       = bus.iren;
    assign daddr_v[g]      = bus.daddr;
    assign dstore_v[g]     = bus.dstore;
    assign iaddr_v[g]      = bus.iaddr;
    assign dump_valid_v[g] = bus.dump_valid;
    assign dump_addr_v[g]  = bus.dump_addr;
    assign dump_data_v[g]  = bus.dump_data;
  end

  function automatic logic [31:0] mem_val(int i, logic [31:0] k);
    case (i)
      0: return k + 32'd1;
      1: return 32'hA0 + k;
      2: case (k)
           32'd0:   return 32'd5;
           32'd1:   return 32'd0;
           32'd2:   return 32'd7;
           default: return 32'hBAD0_0000;
         endcase
      default: return 32'hBAD0_0001;
    endcase
  endfunction

  always_comb begin
    for (int i = 0; i < NI; i++) begin
      dwait_v[i]      = dren_v[i] && (wcnt[i] < wait_cfg[i]);
      dump_ready_v[i] = scnt[i] >= stall_cfg[i];
      dload_v[i]      = dwait_v[i] ? 32'hDEAD_BEEF : mem_val(i, (daddr_v[i] - BASES[i]) >> 2);
    end
  end

  always_ff @(posedge CLK) begin
    for (int i = 0; i < NI; i++) begin
      if (!nRST) begin
        wcnt[i] <= 0;
        scnt[i] <= 0;
      end else begin
        wcnt[i] <= (dren_v[i] && dwait_v[i]) ? wcnt[i] + 1 : 0;
        scnt[i] <= (dump_valid_v[i] && !dump_ready_v[i]) ? scnt[i] + 1 : 0;
      end
    end
  end

  typedef struct { int inst; logic [31:0] a; logic [31:0] d; } exp_t;
  typedef struct { int inst; int wc; int sc; int cyc; } vec_t;

  exp_t exp_q [$];
  vec_t vecs [8];
  int errors = 0;
  int checks = 0;

  logic        pw [NI];
  logic        ps [NI];
  logic [31:0] pa [NI];
  logic [31:0] psa [NI];
  logic [31:0] psd [NI];

  task automatic check32(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic push(int i, logic [31:0] a, logic [31:0] d);
    exp_t e;
    e.inst = i; e.a = a; e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic push_expected(int i);
    case (i)
      0: begin
        push(0, 32'h100, 32'd1); push(0, 32'h104, 32'd2);
        push(0, 32'h108, 32'd3); push(0, 32'h10C, 32'd4);
      end
      1: begin
        push(1, 32'hFFFF_FFFC, 32'hA0); push(1, 32'h0000_0000, 32'hA1);
      end
      2: begin
        push(2, 32'h200, 32'd5);
`ifndef RAM_DUMP_SKIP_ZERO_EN
        push(2, 32'h204, 32'd0);
`endif
        push(2, 32'h208, 32'd7);
      end
      default: ;
    endcase
  endtask

  // Scoreboard pop plus hold-stability checks while waiting on dwait / dump_ready.
  task automatic monitor();
    exp_t e;
    for (int i = 0; i < NI; i++) begin
      if (nRST) begin
        if (dump_valid_v[i] && dump_ready_v[i]) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_word: inst %0d got (%h,%h) required none", i, dump_addr_v[i], dump_data_v[i]);
          end else begin
            e = exp_q.pop_front();
            check32("word_inst", i, e.inst);
            check32("word_addr", dump_addr_v[i], e.a);
            check32("word_data", dump_data_v[i], e.d);
          end
        end
        if (pw[i]) begin
          check32("dren_hold", 32'(dren_v[i]), 32'd1);
          check32("daddr_hold", daddr_v[i], pa[i]);
        end
        if (ps[i]) begin
          check32("valid_hold", 32'(dump_valid_v[i]), 32'd1);
          check32("addr_hold", dump_addr_v[i], psa[i]);
          check32("data_hold", dump_data_v[i], psd[i]);
          check32("no_dren_in_out", 32'(dren_v[i]), 32'd0);
        end
      end
      pw[i]  = nRST && dren_v[i] && dwait_v[i];
      pa[i]  = daddr_v[i];
      ps[i]  = nRST && dump_valid_v[i] && !dump_ready_v[i];
      psa[i] = dump_addr_v[i];
      psd[i] = dump_data_v[i];
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    monitor();
  endtask

  task automatic check_quiet(int i, string name);
    check32({name, "_ctl"}, {25'd0, ovr_v[i], dren_v[i], busy_v[i], done_v[i], dump_valid_v[i], dwen_v[i], iren_v[i]}, 32'd0);
    check32({name, "_daddr"}, daddr_v[i], 32'd0);
    check32({name, "_dump_addr"}, dump_addr_v[i], 32'd0);
    check32({name, "_dump_data"}, dump_data_v[i], 32'd0);
    check32({name, "_dstore_iaddr"}, dstore_v[i] | iaddr_v[i], 32'd0);
  endtask

  task automatic wait_done(int i, inout int cyc, input int limit);
    while (!done_v[i] && cyc < limit) begin
      tick();
      cyc++;
    end
  endtask

  task automatic run(int i, int wc, int sc, int exp_cyc, string name);
    int cyc;
    wait_cfg[i]  = wc;
    stall_cfg[i] = sc;
    push_expected(i);
    start_v[i] = 1'b1;
    tick();
    start_v[i] = 1'b0;
    cyc = 1;
    check32({name, "_busy"}, 32'(busy_v[i]), 32'd1);
    wait_done(i, cyc, 500);
    check32({name, "_done_cycle"}, cyc, exp_cyc);
    tick();
    check32({name, "_left"}, 32'(exp_q.size()), 32'd0);
    check32({name, "_after_done"}, {30'd0, busy_v[i], done_v[i]}, 32'd0);
    exp_q.delete();
  endtask

  initial begin
    int cyc;
    vecs[0] = '{0, 0, 0, 9};
    vecs[1] = '{0, 3, 0, 21};
    vecs[2] = '{0, 0, 5, 29};
    vecs[3] = '{0, 1, 2, 21};
    vecs[4] = '{1, 0, 0, 5};
    vecs[5] = '{3, 0, 0, 1};
    vecs[6] = '{2, 0, 0, (SKIP != 0) ? 6 : 7};
    vecs[7] = '{2, 2, 1, (SKIP != 0) ? 14 : 16};

    nRST = 1'b0;
    start_v = '0;
    for (int i = 0; i < NI; i++) begin
      wait_cfg[i] = 0; stall_cfg[i] = 0;
      pw[i] = 1'b0; ps[i] = 1'b0;
    end
    tick(); tick();
    for (int i = 0; i < NI; i++) check_quiet(i, $sformatf("reset%0d", i));
    nRST = 1'b1;
    tick();

    for (int k = 0; k < 8; k++)
      run(vecs[k].inst, vecs[k].wc, vecs[k].sc, vecs[k].cyc, $sformatf("vec%0d", k));

    // start held high through DONE restarts on the next IDLE cycle
    wait_cfg[0] = 0; stall_cfg[0] = 0;
    push_expected(0);
    push_expected(0);
    start_v[0] = 1'b1;
    tick();
    cyc = 1;
    wait_done(0, cyc, 100);
    check32("hold_first_done", cyc, 9);
    tick(); cyc++;
    check32("hold_idle_gap", 32'(busy_v[0]), 32'd0);
    tick(); cyc++;
    check32("hold_restart", 32'(busy_v[0]), 32'd1);
    start_v[0] = 1'b0;
    wait_done(0, cyc, 200);
    check32("hold_second_done", cyc, 19);
    tick();
    check32("hold_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();

    // reset while word 2 is stuck in READ
    wait_cfg[0] = 10;
    push_expected(0);
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    cyc = 0;
    while (!(dren_v[0] && daddr_v[0] == 32'h104) && cyc < 100) begin
      tick();
      cyc++;
    end
    check32("mid_read_reached", 32'(dren_v[0] && dwait_v[0]), 32'd1);
    nRST = 1'b0;
    tick();
    check_quiet(0, "mid_reset");
    exp_q.delete();
    nRST = 1'b1;
    tick();
    run(0, 0, 0, 9, "restart");
    check_quiet(0, "final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
